// File: rtl/grasshopper_round_ctrl.sv
// grasshopper_round_ctrl: Kuznyechik ten-round sequencer; decrypt path compiled in by GRASSHOPPER_DECRYPT_EN
module grasshopper_round_ctrl #(
   parameter int NROUNDS = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic [127:0] in_data_i,
`ifdef GRASSHOPPER_DECRYPT_EN
   input  logic         mode_i,
`endif
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic [127:0] out_data_o,
   output logic [3:0]   key_idx_o,
   input  logic [127:0] key_i,
   output logic [127:0] dp_state_o,
   output logic [127:0] dp_key_o,
   output logic         dp_inv_o,
   input  logic [127:0] dp_result_i,
   output logic         busy_o
);
   localparam logic [3:0] LAST_KEY = 4'(NROUNDS - 1);
   localparam logic [3:0] LAST_RC  = 4'(NROUNDS - 2);

   typedef enum logic [2:0] {
      IDLE,
`ifdef GRASSHOPPER_DECRYPT_EN
      PRE,
`endif
      ROUND,
      FINAL,
      DONE
   } fsm_t;

   fsm_t         r_fsm;
   logic [127:0] r_state;
   logic [3:0]   r_rc;
   logic         w_keyxor;

`ifdef GRASSHOPPER_DECRYPT_EN
   logic r_mode;
   assign dp_inv_o = r_mode;
   assign w_keyxor = (r_fsm == FINAL) || (r_fsm == PRE);
`else
   assign dp_inv_o = 1'b0;
   assign w_keyxor = (r_fsm == FINAL);
`endif

   assign in_ready_o  = (r_fsm == IDLE);
   assign out_valid_o = (r_fsm == DONE);
   assign busy_o      = (r_fsm != IDLE);
   assign out_data_o  = r_state;
   assign dp_state_o  = r_state;
   assign dp_key_o    = key_i;
   assign key_idx_o   = (r_fsm == ROUND) ? r_rc : w_keyxor ? LAST_KEY : 4'd0;

   // Block sequencing: load, optional pre-whitening, nine datapath rounds, final whitening, hold result
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_fsm   <= IDLE;
         r_state <= '0;
         r_rc    <= '0;
`ifdef GRASSHOPPER_DECRYPT_EN
         r_mode  <= 1'b0;
`endif
      end else begin
         case (r_fsm)
            IDLE: if (in_valid_i) begin
               r_state <= in_data_i;
               r_rc    <= '0;
`ifdef GRASSHOPPER_DECRYPT_EN
               r_mode  <= mode_i;
               r_fsm   <= mode_i ? PRE : ROUND;
`else
               r_fsm   <= ROUND;
`endif
            end
`ifdef GRASSHOPPER_DECRYPT_EN
            PRE: begin
               r_state <= r_state ^ key_i;
               r_rc    <= LAST_RC;
               r_fsm   <= ROUND;
            end
`endif
            ROUND: begin
               r_state <= dp_result_i;
`ifdef GRASSHOPPER_DECRYPT_EN
               if (r_mode) begin
                  r_rc <= r_rc - 4'd1;
                  if (r_rc == 4'd0) r_fsm <= DONE;
               end else
`endif
               begin
                  r_rc <= r_rc + 4'd1;
                  if (r_rc == LAST_RC) r_fsm <= FINAL;
               end
            end
            FINAL: begin
               r_state <= r_state ^ key_i;
               r_fsm   <= DONE;
            end
            DONE: begin
               r_rc <= '0;
               if (out_ready_i) r_fsm <= IDLE;
            end
            default: r_fsm <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_grasshopper_round_ctrl.sv
// tb_grasshopper_round_ctrl: vector table plus scoreboard bench with stub and invertible toy datapaths
module tb_grasshopper_round_ctrl;
   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic         mode = 1'b0;
   logic         stub = 1'b1;
   logic [127:0] in_data = '0;
   logic         in_ready, out_valid, busy, dp_inv;
   logic [127:0] out_data, dp_state, dp_key, dp_result, key;
   logic [3:0]   key_idx;

   typedef struct {
      logic         s;
      logic         m;
      logic [127:0] d;
      logic [127:0] e;
   } vec_t;

   vec_t         vt[$];
   logic [127:0] sb[$];
   int           n_chk = 0;
   int           n_fail = 0;

   always #5 clk = ~clk;

   function automatic logic [127:0] kfun(input logic [3:0] i);
      logic [31:0] w;
      w = {28'd0, i};
      return {w * 32'h9E3779B9, w ^ 32'hDEADBEEF, ~w, w * 32'h01000193 + 32'h55};
   endfunction

   function automatic logic [127:0] e_rnd(input logic [127:0] s, input logic [127:0] k);
      logic [127:0] t;
      t = s ^ k;
      return {t[124:0], t[127:125]} + 128'd1;
   endfunction

   function automatic logic [127:0] d_rnd(input logic [127:0] s, input logic [127:0] k);
      logic [127:0] t;
      t = s - 128'd1;
      return {t[2:0], t[127:3]} ^ k;
   endfunction

   function automatic logic [127:0] ref_enc(input logic [127:0] x);
      logic [127:0] s;
      s = x;
      for (int i = 0; i < 9; i++) s = e_rnd(s, kfun(4'(i)));
      return s ^ kfun(4'd9);
   endfunction

   function automatic logic [127:0] ref_dec(input logic [127:0] x);
      logic [127:0] s;
      s = x ^ kfun(4'd9);
      for (int i = 8; i >= 0; i--) s = d_rnd(s, kfun(4'(i)));
      return s;
   endfunction

   function automatic logic [3:0] exp_idx(input logic m, input int k);
      if (m) return (k == 1) ? 4'd9 : 4'(10 - k);
      return (k == 10) ? 4'd9 : 4'(k - 1);
   endfunction

   assign key       = stub ? {124'd0, key_idx} : kfun(key_idx);
   assign dp_result = stub ? dp_state + 128'd1 : (dp_inv ? d_rnd(dp_state, dp_key) : e_rnd(dp_state, dp_key));

   grasshopper_round_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid_i (in_valid),
      .in_ready_o (in_ready),
      .in_data_i  (in_data),
`ifdef GRASSHOPPER_DECRYPT_EN
      .mode_i     (mode),
`endif
      .out_valid_o(out_valid),
      .out_ready_i(out_ready),
      .out_data_o (out_data),
      .key_idx_o  (key_idx),
      .key_i      (key),
      .dp_state_o (dp_state),
      .dp_key_o   (dp_key),
      .dp_inv_o   (dp_inv),
      .dp_result_i(dp_result),
      .busy_o     (busy)
   );

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string nm);
      chk({nm, "_in_ready"}, 128'(in_ready), 128'd1);
      chk({nm, "_out_valid"}, 128'(out_valid), 128'd0);
      chk({nm, "_busy"}, 128'(busy), 128'd0);
      chk({nm, "_key_idx"}, 128'(key_idx), 128'd0);
      chk({nm, "_dp_inv"}, 128'(dp_inv), 128'd0);
      chk({nm, "_out_data"}, out_data, 128'd0);
   endtask

   task automatic finish_out(input string nm);
      int t;
      t = 0;
      while (!out_valid && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk({nm, "_valid"}, 128'(out_valid), 128'd1);
      if (sb.size() == 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL %s_sb: got output %h expected no output pending", nm, out_data);
      end else chk({nm, "_data"}, out_data, sb.pop_front());
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({nm, "_back_idle"}, 128'(in_ready), 128'd1);
   endtask

   task automatic run_block(input string nm, input logic s, input logic m, input logic [127:0] d, input logic [127:0] e);
      logic [3:0] ix;
      stub = s;
      chk({nm, "_rdy"}, 128'(in_ready), 128'd1);
      in_valid = 1'b1;
      in_data  = d;
      mode     = m;
      sb.push_back(e);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k == 1) begin
            in_valid = 1'b0;
            in_data  = {4{$urandom()}};
            mode     = ~m;
         end
         ix = exp_idx(m, k);
         chk($sformatf("%s_idx%0d", nm, k), 128'(key_idx), 128'(ix));
         chk($sformatf("%s_key%0d", nm, k), dp_key, s ? {124'd0, ix} : kfun(ix));
         chk($sformatf("%s_inv%0d", nm, k), 128'(dp_inv), 128'(m));
         chk($sformatf("%s_busy%0d", nm, k), 128'(busy), 128'd1);
         chk($sformatf("%s_early%0d", nm, k), 128'(out_valid), 128'd0);
      end
      @(negedge clk);
      chk({nm, "_lat"}, 128'(out_valid), 128'd1);
      finish_out(nm);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic [127:0] p;
      p = 128'h1122334455667700ffeeddccbbaa9988;
      vt.push_back('{1'b1, 1'b0, 128'd0, 128'd0});
      vt.push_back('{1'b1, 1'b0, 128'd5, 128'd7});
      vt.push_back('{1'b1, 1'b0, '1, 128'd1});
      vt.push_back('{1'b0, 1'b0, p, ref_enc(p)});
      vt.push_back('{1'b0, 1'b0, 128'd0, ref_enc(128'd0)});
      vt.push_back('{1'b0, 1'b0, 128'hDEADBEEF_0BADF00D_CAFEBABE_12345678, ref_enc(128'hDEADBEEF_0BADF00D_CAFEBABE_12345678)});
`ifdef GRASSHOPPER_DECRYPT_EN
      vt.push_back('{1'b1, 1'b1, 128'd0, 128'd18});
      vt.push_back('{1'b0, 1'b1, ref_enc(p), p});
      vt.push_back('{1'b0, 1'b1, p, ref_dec(p)});
`endif

      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      rst = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk($sformatf("idle_ready%0d", i), 128'(in_ready), 128'd1);
         chk($sformatf("idle_valid%0d", i), 128'(out_valid), 128'd0);
         chk($sformatf("idle_idx%0d", i), 128'(key_idx), 128'd0);
      end

      for (int i = 0; i < vt.size(); i++)
         run_block($sformatf("vec%0d", i), vt[i].s, vt[i].m, vt[i].d, vt[i].e);

      stub = 1'b1;
      in_valid = 1'b1;
      in_data  = 128'd0;
      mode     = 1'b0;
      sb.push_back(128'd0);
      @(negedge clk);
      in_valid = 1'b0;
      for (int t = 0; t < 20 && !out_valid; t++) @(negedge clk);
      for (int i = 0; i < 30; i++) begin
         in_valid = (i % 3 == 0);
         in_data  = 128'd5;
         @(negedge clk);
         chk($sformatf("bp_valid%0d", i), 128'(out_valid), 128'd1);
         chk($sformatf("bp_data%0d", i), out_data, 128'd0);
         chk($sformatf("bp_ready%0d", i), 128'(in_ready), 128'd0);
      end
      chk("bp_out", out_data, sb.pop_front());
      sb.push_back(128'd7);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("bp_idle_ready", 128'(in_ready), 128'd1);
      chk("bp_idle_busy", 128'(busy), 128'd0);
      @(negedge clk);
      in_valid = 1'b0;
      chk("bp_next_busy", 128'(busy), 128'd1);
      chk("bp_next_idx", 128'(key_idx), 128'd0);
      finish_out("bp_next");

      stub = 1'b0;
      in_valid = 1'b1;
      in_data  = p;
      mode     = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("abort_idx", 128'(key_idx), 128'd4);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      chk_reset_outputs("abort");
      run_block("fresh", 1'b0, 1'b0, p, ref_enc(p));
      chk("sb_empty", 128'(sb.size()), 128'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
